// File: rtl/data_mem_store_ctrl_if.sv
// data_mem_store_ctrl_if: core request and word-memory bus bundle for data_mem_store_ctrl.
//   Core side : req_valid, req_address, req_data, req_read_write (1=store),
//               req_access_size (1=byte) in; busy, done, rdata out.
//   Memory side: mem_address, mem_data_in, mem_read_write (1=write), mem_enable out;
//               mem_data_out, mem_busy in.
//   slave modport is the controller view, master modport is the environment view.
interface data_mem_store_ctrl_if;
  logic        req_valid;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic        req_read_write;
  logic        req_access_size;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read_write;
  logic        mem_enable;
  logic [31:0] mem_data_out;
  logic        mem_busy;
  modport slave (
    input  req_valid, req_address, req_data, req_read_write, req_access_size,
    input  mem_data_out, mem_busy,
    output busy, done, rdata,
    output mem_address, mem_data_in, mem_read_write, mem_enable
  );
  modport master (
    output req_valid, req_address, req_data, req_read_write, req_access_size,
    output mem_data_out, mem_busy,
    input  busy, done, rdata,
    input  mem_address, mem_data_in, mem_read_write, mem_enable
  );
endinterface

// File: rtl/data_mem_store_ctrl.sv
// data_mem_store_ctrl: sequences loads, word stores and byte-store read-modify-writes onto a word memory.
//   i_clock   : rising-edge clock
//   i_reset_n : asynchronous active-low reset
//   bus       : data_mem_store_ctrl_if.slave (core request/response + memory bus)
//   Optional STORE_WORD_BUFFER_EN: one-entry written-word buffer lets a byte store
//   hitting the last written word skip the read access.
module data_mem_store_ctrl (
  input logic                  i_clock,
  input logic                  i_reset_n,
  data_mem_store_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACCESS, RD, MERGE, WR} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr, r_data, r_word, r_rdata;
  logic        r_rw, r_done;
  logic        w_accept, w_mem_done, w_hit, w_byte_store;
  logic        w_mem_enable, w_mem_rw;
  logic [31:0] w_merged, w_buf_word;
  assign w_accept     = (r_state == IDLE) && bus.req_valid;
  assign w_byte_store = bus.req_read_write && bus.req_access_size;
  assign w_mem_done   = w_mem_enable && !bus.mem_busy;
  // Big-endian lanes: byte offset 0 is the most significant byte.
  assign w_merged = (r_addr[1:0] == 2'd0) ? {r_data[7:0], r_word[23:0]} :
                    (r_addr[1:0] == 2'd1) ? {r_word[31:24], r_data[7:0], r_word[15:0]} :
                    (r_addr[1:0] == 2'd2) ? {r_word[31:16], r_data[7:0], r_word[7:0]} :
                                            {r_word[31:8], r_data[7:0]};
`ifdef STORE_WORD_BUFFER_EN
  logic        r_buf_valid;
  logic [29:0] r_buf_addr;
  logic [31:0] r_buf_word;
  assign w_hit      = r_buf_valid && (r_buf_addr == bus.req_address[31:2]);
  assign w_buf_word = r_buf_word;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_word  <= '0;
    end else if (r_state == WR && w_mem_done) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= r_addr[31:2];
      r_buf_word  <= r_word;
    end else if (r_state == ACCESS && w_mem_done && r_rw) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= r_addr[31:2];
      r_buf_word  <= r_data;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_buf_word = '0;
`endif
  always_comb begin
    w_next       = r_state;
    w_mem_enable = 1'b0;
    w_mem_rw     = 1'b0;
    case (r_state)
      IDLE:   if (bus.req_valid) w_next = w_byte_store ? (w_hit ? MERGE : RD) : ACCESS;
      ACCESS: begin
        w_mem_enable = 1'b1;
        w_mem_rw     = r_rw;
        if (!bus.mem_busy) w_next = IDLE;
      end
      RD: begin
        w_mem_enable = 1'b1;
        if (!bus.mem_busy) w_next = MERGE;
      end
      MERGE:  w_next = WR;
      WR: begin
        w_mem_enable = 1'b1;
        w_mem_rw     = 1'b1;
        if (!bus.mem_busy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_rw    <= 1'b0;
      r_word  <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ACCESS || r_state == WR) && w_mem_done;
      if (w_accept) begin
        r_addr <= bus.req_address;
        r_data <= bus.req_data;
        r_rw   <= bus.req_read_write;
      end
      if (r_state == RD && w_mem_done)
        r_word <= bus.mem_data_out;
      else if (r_state == MERGE)
        r_word <= w_merged;
      else if (w_accept && w_hit)
        r_word <= w_buf_word;
      if (r_state == ACCESS && w_mem_done && !r_rw)
        r_rdata <= bus.mem_data_out;
    end
  end
  assign bus.busy           = (r_state != IDLE);
  assign bus.done           = r_done;
  assign bus.rdata          = r_rdata;
  assign bus.mem_enable     = w_mem_enable;
  assign bus.mem_read_write = w_mem_rw;
  assign bus.mem_address    = {r_addr[31:2], 2'b00};
  assign bus.mem_data_in    = (r_state == WR) ? r_word : r_data;
endmodule

// File: tb/tb_data_mem_store_ctrl.sv
// tb_data_mem_store_ctrl: directed self-checking bench for data_mem_store_ctrl with a word memory model.
module tb_data_mem_store_ctrl;
`ifdef STORE_WORD_BUFFER_EN
  localparam int BUF = 1;
`else
  localparam int BUF = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat, wr_before, rd_before;
  int   stall_done = 0;
  int   stall_target = 0;
  int   wr_count = 0;
  int   rd_count = 0;
  logic [31:0] mem [0:511] = '{default: '0};
  data_mem_store_ctrl_if bus ();
  data_mem_store_ctrl dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_busy     = (stall_done < stall_target);
  assign bus.mem_data_out = mem[bus.mem_address[10:2]];
  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_busy) stall_done <= stall_done + 1;
    if (bus.mem_enable && !bus.mem_busy && bus.mem_read_write) begin
      mem[bus.mem_address[10:2]] <= bus.mem_data_in;
      wr_count <= wr_count + 1;
    end
    if (bus.mem_enable && !bus.mem_busy && !bus.mem_read_write) rd_count <= rd_count + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_req(input logic rw, input logic sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid       = 1'b1;
    bus.req_read_write  = rw;
    bus.req_access_size = sz;
    bus.req_address     = a;
    bus.req_data        = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_done(inout int l);
    while (bus.done !== 1'b1 && l < 40) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask
  task automatic do_req(input logic rw, input logic sz, input logic [31:0] a, input logic [31:0] d, output int l);
    start_req(rw, sz, a, d);
    l = 1;
    wait_done(l);
  endtask
  initial begin
    bus.req_valid       = 1'b0;
    bus.req_read_write  = 1'b0;
    bus.req_access_size = 1'b0;
    bus.req_address     = '0;
    bus.req_data        = '0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_enable", 32'(bus.mem_enable), 0);
    chk("rst_mem_rw", 32'(bus.mem_read_write), 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_data_in", bus.mem_data_in, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, lat);
    chk("wstore_lat", 32'(lat), 2);
    chk("wstore_mem", mem[9'h040], 32'hDEADBEEF);
    do_req(1'b0, 1'b0, 32'h100, 32'h0, lat);
    chk("load_lat", 32'(lat), 2);
    chk("load_rdata", bus.rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("rdata_hold", bus.rdata, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h100, 32'h11223344, lat);
    chk("preload_lat", 32'(lat), 2);
    do_req(1'b1, 1'b1, 32'h101, 32'h000000AA, lat);
    chk("bstore_lat", 32'(lat), BUF ? 3 : 4);
    chk("bstore_word", mem[9'h040], 32'h11AA3344);
    chk("bstore_keeps_rdata", bus.rdata, 32'hDEADBEEF);
    do_req(1'b1, 1'b1, 32'h203, 32'h00000055, lat);
    chk("b203_lat", 32'(lat), 4);
    chk("b203_word", mem[9'h080], 32'h00000055);
    do_req(1'b1, 1'b1, 32'h200, 32'hFFFFFF66, lat);
    chk("b200_lat", 32'(lat), BUF ? 3 : 4);
    chk("b200_word", mem[9'h080], 32'h66000055);
    do_req(1'b0, 1'b0, 32'h202, 32'h0, lat);
    chk("unaligned_load_rdata", bus.rdata, 32'h66000055);
    stall_target = stall_done + 3;
    start_req(1'b1, 1'b1, 32'h502, 32'h00000099);
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", bus.mem_address, 32'h500);
      chk("stall_busy", 32'(bus.busy), 1);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("stall_addr_end", bus.mem_address, 32'h500);
    wait_done(lat);
    chk("stall_lat", 32'(lat), 7);
    chk("stall_word", mem[9'h140], 32'h00009900);
    do_req(1'b1, 1'b0, 32'h400, 32'hCAFEF00D, lat);
    wr_before = wr_count;
    start_req(1'b1, 1'b1, 32'h401, 32'h00000077);
    repeat (BUF ? 0 : 1) begin
      @(posedge clk);
      #1;
    end
    chk("merge_busy", 32'(bus.busy), 1);
    chk("merge_enable", 32'(bus.mem_enable), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_enable", 32'(bus.mem_enable), 0);
    chk("rstmid_rdata", bus.rdata, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_no_write", 32'(wr_count), 32'(wr_before));
    do_req(1'b0, 1'b0, 32'h400, 32'h0, lat);
    chk("rstmid_word", bus.rdata, 32'hCAFEF00D);
    stall_target = stall_done + 5;
    start_req(1'b1, 1'b1, 32'h600, 32'h00000012);
    chk("rd_enable", 32'(bus.mem_enable), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstrd_enable", 32'(bus.mem_enable), 0);
    chk("rstrd_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_target = stall_done;
    do_req(1'b1, 1'b1, 32'h300, 32'h000000A1, lat);
    chk("b300_lat", 32'(lat), 4);
    rd_before = rd_count;
    do_req(1'b1, 1'b1, 32'h302, 32'h000000B2, lat);
    chk("b302_lat", 32'(lat), BUF ? 3 : 4);
    chk("b302_reads", 32'(rd_count - rd_before), BUF ? 0 : 1);
    chk("b302_word", mem[9'h0C0], 32'hA100B200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_store_ctrl.md
# data_mem_store_ctrl

Sequencing controller between the core's memory-stage request and the word-wide `data_memory`. Loads and word stores pass through as a single memory access. Byte stores become a read-modify-write: read the word, merge the byte into the addressed big-endian lane, write the word back. Raw load words go downstream to the load-extraction stage, which does the byte selection and sign extension.

## Interface
Parameters: none.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present; sampled only in IDLE.
- `req_address`  in  32  byte address.
- `req_data`  in  32  store data; byte stores use `[7:0]`.
- `req_read_write`  in  1  1 = store, 0 = load.
- `req_access_size`  in  1  1 = byte, 0 = word.
- `busy`  out  1  request in flight; core must stall.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  raw load word; valid while `done` is high.
- `mem_address`  out  32  word-aligned address: `{addr[31:2],2'b00}`.
- `mem_data_in`  out  32  write data to memory.
- `mem_read_write`  out  1  1 = write.
- `mem_enable`  out  1  access request, held until accepted.
- `mem_data_out`  in  32  memory read data.
- `mem_busy`  in  1  memory not ready.

## Operation
- Memory handshake: an access completes in the first cycle where `mem_enable`=1 and `mem_busy`=0. Read data is sampled in that cycle.
- Request latch: in IDLE with `req_valid`=1, the unit latches address, data, read_write and access_size on the clock edge. Request inputs are ignored until the unit returns to IDLE.
- States:
  - IDLE: `busy`=0. A load or word store goes to ACCESS. A byte store goes to RD.
  - ACCESS: `mem_enable`=1, `mem_read_write`=latched read_write. On completion, go to IDLE with `done`=1. For loads, also capture `rdata`.
  - RD: `mem_enable`=1, `mem_read_write`=0. On completion, capture the word and go to MERGE.
  - MERGE: `mem_enable`=0. Replace the lane selected by `addr[1:0]` with `data[7:0]`: 00→[31:24], 01→[23:16], 10→[15:8], 11→[7:0]. Go to WR.
  - WR: `mem_enable`=1, `mem_read_write`=1, `mem_data_in`=merged word. On completion, go to IDLE with `done`=1.
- `busy`=1 in every state except IDLE.
- `done` is registered. It is high for the single IDLE cycle that follows completion, and a new request may be accepted in that same cycle.
- `rdata` holds its last value until the next load completes. Stores do not modify it.
- The byte-access sign flag stays downstream; this block never alters load data.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rdata`=0, `mem_enable`=0, `mem_read_write`=0, `mem_address`=0, `mem_data_in`=0.
- Zero-wait-state latency (acceptance edge to `done` high):
  - Load or word store: 2 cycles.
  - Byte store: 4 cycles.
- Each cycle of `mem_busy`=1 during a `mem_enable` cycle adds one cycle. `mem_address` and `mem_data_in` stay stable throughout.
- Reset mid-operation: all state clears immediately and asynchronously, and `mem_enable` drops at once. A partially completed RMW is abandoned; the WR access is never issued.
- Unaligned word address: low two bits are silently dropped.

## Configuration
- `STORE_WORD_BUFFER_EN` defined: adds a one-entry buffer {valid, word address, word}.
  - Updated with the merged word on every byte-store WR completion, and with the written word on every word-store completion.
  - A byte store whose word address matches a valid entry skips RD: IDLE→MERGE→WR, latency 3.
  - A load never updates the buffer.
  - Reset clears valid.
- Undefined: no buffer. Every byte store performs RD.

## Test plan
- Word store to 0x100 with data 0xDEADBEEF, then a load from 0x100, `mem_busy`=0 → each `done` arrives 2 cycles after acceptance, and `rdata`=0xDEADBEEF.
- Memory word 0x11223344, byte store 0xAA to 0x101 → WR data 0x11AA3344, `done` 4 cycles after acceptance.
- Byte stores 0x55 to 0x203, then 0x66 to 0x200, over initial 0x00000000 → final word 0x66000055.
- `mem_busy`=1 for 3 cycles during RD of a byte store → `mem_address` stays stable, latency 7, merged result correct.
- `reset_n` low during MERGE → `mem_enable`=0 and `busy`=0 immediately, no write issued, memory word unchanged.
- With `STORE_WORD_BUFFER_EN`: two consecutive byte stores to 0x300 and 0x302 → the second has no RD access and latency 3.
